// File: rtl/usb_rx_pkg.sv
// rtl/usb_rx_pkg.sv - shared types and constants for the USB receive controller
package usb_rx_pkg;

    typedef enum logic [3:0] {
        IDLE,
        SYNC_RX,
        SYNC_CHK,
        DATA_RX,
        STORE,
        EOP_WAIT,
        ERR_WAIT,
        ERR_EOP,
        ERR_IDLE
    } state_t;

    localparam logic [7:0] SYNC_BYTE = 8'h80;
    localparam int         MAX_BYTES = 64;
    localparam int         CNT_W     = 7;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BYTES);

`ifdef USB_RX_PID_CHECK_EN
    // A PID byte carries its own one's complement in the upper nibble.
    function automatic logic pid_ok(input logic [7:0] pid);
        return pid[7:4] == ~pid[3:0];
    endfunction
`endif

endpackage

// File: rtl/usb_rx_byte_cnt.sv
// rtl/usb_rx_byte_cnt.sv - saturating per-packet byte counter with clear and increment
module usb_rx_byte_cnt
    import usb_rx_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             incr,
    output logic [CNT_W-1:0] count
);

    // Clear has priority; the count sticks at MAX_CNT instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (incr && (count < MAX_CNT)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/usb_rx_ctrl.sv
// rtl/usb_rx_ctrl.sv - USB packet receive control FSM (optional PID check: USB_RX_PID_CHECK_EN)
module usb_rx_ctrl
    import usb_rx_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             d_edge,
    input  logic             eop,
    input  logic             shift_enable,
    input  logic             byte_received,
    input  logic [7:0]       rcv_data,
    output logic             rcving,
    output logic             w_enable,
    output logic             r_error,
    output logic             packet_done,
    output logic [CNT_W-1:0] byte_count
);

    state_t state;
    state_t next_state;
    logic   eop_strobe;
    logic   cnt_clear;
    logic   last_slot;

    assign eop_strobe = eop && shift_enable;
    assign last_slot  = (byte_count >= (MAX_CNT - 1'b1));

    // State register; reset parks the FSM in IDLE regardless of clk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and Moore output decode; packet_done is the only Mealy term.
    always_comb begin
        next_state  = state;
        rcving      = 1'b0;
        w_enable    = 1'b0;
        r_error     = 1'b0;
        packet_done = 1'b0;
        cnt_clear   = 1'b0;
        case (state)
            IDLE: begin
                if (d_edge) begin
                    next_state = SYNC_RX;
                    cnt_clear  = 1'b1;
                end
            end
            SYNC_RX: begin
                rcving = 1'b1;
                if (eop_strobe)         next_state = ERR_EOP;
                else if (byte_received) next_state = SYNC_CHK;
            end
            SYNC_CHK: begin
                rcving     = 1'b1;
                next_state = (rcv_data == SYNC_BYTE) ? DATA_RX : ERR_WAIT;
            end
            DATA_RX: begin
                rcving = 1'b1;
                // A byte completing alongside EOP is a stuffing artefact, not data.
                if (eop_strobe)         next_state = EOP_WAIT;
                else if (byte_received) next_state = STORE;
            end
            STORE: begin
                rcving   = 1'b1;
                w_enable = 1'b1;
                if (last_slot) begin
                    next_state = ERR_WAIT;
`ifdef USB_RX_PID_CHECK_EN
                end else if ((byte_count == '0) && !pid_ok(rcv_data)) begin
                    next_state = ERR_WAIT;
`endif
                end else begin
                    next_state = DATA_RX;
                end
            end
            EOP_WAIT: begin
                rcving = 1'b1;
                if (d_edge) begin
                    next_state  = IDLE;
                    packet_done = 1'b1;
                end
            end
            ERR_WAIT: begin
                rcving  = 1'b1;
                r_error = 1'b1;
                if (eop_strobe) next_state = ERR_EOP;
            end
            ERR_EOP: begin
                rcving  = 1'b1;
                r_error = 1'b1;
                if (d_edge) next_state = ERR_IDLE;
            end
            ERR_IDLE: begin
                r_error = 1'b1;
                if (d_edge) next_state = SYNC_RX;
            end
            default: next_state = IDLE;
        endcase
    end

    usb_rx_byte_cnt u_byte_cnt (
        .clk   (clk),
        .rst   (rst),
        .clear (cnt_clear),
        .incr  (w_enable),
        .count (byte_count)
    );

endmodule

// File: tb/tb_usb_rx_ctrl.sv
// tb/tb_usb_rx_ctrl.sv - scoreboard testbench for usb_rx_ctrl
module tb_usb_rx_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       d_edge, eop, shift_enable, byte_received;
    logic [7:0] rcv_data;
    logic       rcving, w_enable, r_error, packet_done;
    logic [6:0] byte_count;

    int         n_cmp  = 0;
    int         n_fail = 0;
    int         pd_cnt = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    usb_rx_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .d_edge        (d_edge),
        .eop           (eop),
        .shift_enable  (shift_enable),
        .byte_received (byte_received),
        .rcv_data      (rcv_data),
        .rcving        (rcving),
        .w_enable      (w_enable),
        .r_error       (r_error),
        .packet_done   (packet_done),
        .byte_count    (byte_count)
    );

    // Output monitor, sampled mid-cycle: every FIFO write must match the oldest expected byte.
    always @(negedge clk) begin
        if (packet_done === 1'b1) pd_cnt++;
        if (w_enable === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL wr_unexpected: w_enable=1 data=%h, required no write", rcv_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (rcv_data !== e) begin
                    n_fail++;
                    $display("FAIL wr_data: got %h, required %h", rcv_data, e);
                end
            end
        end
    end

    // One clock of stimulus; inputs change 1 time unit after the rising edge.
    task automatic cyc(input logic de, input logic eo, input logic se, input logic br,
                       input logic [7:0] d);
        d_edge = de; eop = eo; shift_enable = se; byte_received = br; rcv_data = d;
        @(posedge clk); #1;
        d_edge = 0; eop = 0; shift_enable = 0; byte_received = 0;
    endtask

    task automatic start_packet();
        cyc(1, 0, 0, 0, 8'h00);
        cyc(0, 0, 0, 1, 8'h80);
        cyc(0, 0, 0, 0, 8'h80);
    endtask

    task automatic send_byte(input logic [7:0] b);
        exp_q.push_back(b);
        cyc(0, 0, 0, 1, b);
        cyc(0, 0, 0, 0, b);
    endtask

    task automatic do_reset();
        rst = 1'b1; #3;
        rst = 1'b0; @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; d_edge = 0; eop = 0; shift_enable = 0; byte_received = 0; rcv_data = 0;
        #3;
        n_cmp++;
        if ({rcving, w_enable, r_error, packet_done, byte_count} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b, required all 0",
                     {rcving, w_enable, r_error, packet_done, byte_count});
        end
        @(posedge clk); #1; rst = 1'b0;
        cyc(0, 0, 0, 0, 8'h00);
        n_cmp++;
        if (rcving !== 1'b0) begin n_fail++; $display("FAIL reset_idle: rcving=%b required 0", rcving); end
    endtask

    task automatic test_clean_packet();
        int pd0;
        pd0 = pd_cnt;
        start_packet();
        n_cmp++;
        if (rcving !== 1'b1 || r_error !== 1'b0) begin
            n_fail++; $display("FAIL clean_rcving: rcving=%b r_error=%b required 1/0", rcving, r_error);
        end
        send_byte(8'hC3);
        send_byte(8'hA5);
        cyc(0, 1, 1, 0, 8'hA5);
        n_cmp++;
        if (byte_count !== 7'd2) begin n_fail++; $display("FAIL clean_count: got %0d required 2", byte_count); end
        n_cmp++;
        if (pd_cnt !== pd0) begin n_fail++; $display("FAIL clean_early_done: got %0d pulses required 0", pd_cnt - pd0); end
        cyc(1, 0, 0, 0, 8'h00);
        n_cmp++;
        if (pd_cnt !== pd0 + 1) begin n_fail++; $display("FAIL clean_done: got %0d pulses required 1", pd_cnt - pd0); end
        n_cmp++;
        if (rcving !== 1'b0 || r_error !== 1'b0) begin
            n_fail++; $display("FAIL clean_end: rcving=%b r_error=%b required 0/0", rcving, r_error);
        end
    endtask

    task automatic test_bad_sync();
        cyc(1, 0, 0, 0, 8'h00);
        cyc(0, 0, 0, 1, 8'h81);
        cyc(0, 0, 0, 0, 8'h81);
        cyc(0, 0, 0, 1, 8'h55);
        n_cmp++;
        if (r_error !== 1'b1 || rcving !== 1'b1) begin
            n_fail++; $display("FAIL badsync_err: r_error=%b rcving=%b required 1/1", r_error, rcving);
        end
        cyc(0, 1, 1, 0, 8'h00);
        cyc(1, 0, 0, 0, 8'h00);
        n_cmp++;
        if (r_error !== 1'b1 || rcving !== 1'b0) begin
            n_fail++; $display("FAIL badsync_erridle: r_error=%b rcving=%b required 1/0", r_error, rcving);
        end
        cyc(1, 0, 0, 0, 8'h00);
        n_cmp++;
        if (r_error !== 1'b0 || rcving !== 1'b1) begin
            n_fail++; $display("FAIL badsync_resume: r_error=%b rcving=%b required 0/1", r_error, rcving);
        end
        do_reset();
    endtask

    task automatic test_early_eop();
        cyc(1, 0, 0, 0, 8'h00);
        cyc(0, 1, 1, 1, 8'h80);
        n_cmp++;
        if (r_error !== 1'b1 || rcving !== 1'b1) begin
            n_fail++; $display("FAIL early_eop: r_error=%b rcving=%b required 1/1", r_error, rcving);
        end
        cyc(0, 0, 0, 0, 8'h00);
        n_cmp++;
        if (r_error !== 1'b1) begin n_fail++; $display("FAIL early_eop_hold: r_error=%b required 1", r_error); end
        do_reset();
    endtask

    task automatic test_simultaneous();
        int pd0;
        start_packet();
        send_byte(8'hC3);
        cyc(0, 1, 1, 1, 8'h77);
        n_cmp++;
        if (byte_count !== 7'd1 || rcving !== 1'b1 || r_error !== 1'b0) begin
            n_fail++; $display("FAIL simul_state: count=%0d rcving=%b r_error=%b required 1/1/0",
                               byte_count, rcving, r_error);
        end
        pd0 = pd_cnt;
        cyc(1, 0, 0, 0, 8'h00);
        n_cmp++;
        if (pd_cnt !== pd0 + 1) begin n_fail++; $display("FAIL simul_done: got %0d pulses required 1", pd_cnt - pd0); end
    endtask

    task automatic test_overflow();
        start_packet();
        for (int i = 0; i < 64; i++) begin
            send_byte((i == 0) ? 8'hC3 : 8'(i));
            if (i == 62) begin
                n_cmp++;
                if (r_error !== 1'b0 || byte_count !== 7'd63) begin
                    n_fail++; $display("FAIL ovf_63: r_error=%b count=%0d required 0/63", r_error, byte_count);
                end
            end
        end
        n_cmp++;
        if (r_error !== 1'b1 || byte_count !== 7'd64) begin
            n_fail++; $display("FAIL ovf_64: r_error=%b count=%0d required 1/64", r_error, byte_count);
        end
        cyc(0, 0, 0, 1, 8'h99);
        cyc(0, 0, 0, 0, 8'h99);
        n_cmp++;
        if (byte_count !== 7'd64) begin n_fail++; $display("FAIL ovf_sat: count=%0d required 64", byte_count); end
        do_reset();
    endtask

    task automatic test_reset_mid_packet();
        int pd0;
        pd0 = pd_cnt;
        start_packet();
        send_byte(8'hC3);
        cyc(0, 0, 0, 1, 8'h11);
        #1 rst = 1'b1;
        #1;
        n_cmp++;
        if ({rcving, w_enable, r_error, packet_done, byte_count} !== 11'd0) begin
            n_fail++; $display("FAIL rst_async: got %b required all 0",
                               {rcving, w_enable, r_error, packet_done, byte_count});
        end
        @(posedge clk); #1; rst = 1'b0;
        cyc(0, 1, 1, 0, 8'h00);
        cyc(1, 0, 0, 0, 8'h00);
        n_cmp++;
        if (rcving !== 1'b1 || pd_cnt !== pd0) begin
            n_fail++; $display("FAIL rst_resume: rcving=%b done_pulses=%0d required 1/0", rcving, pd_cnt - pd0);
        end
        do_reset();
    endtask

    task automatic test_pid();
        start_packet();
        send_byte(8'hC4);
`ifdef USB_RX_PID_CHECK_EN
        n_cmp++;
        if (r_error !== 1'b1) begin n_fail++; $display("FAIL pid_bad: r_error=%b required 1", r_error); end
`else
        n_cmp++;
        if (r_error !== 1'b0 || byte_count !== 7'd1) begin
            n_fail++; $display("FAIL pid_nocheck: r_error=%b count=%0d required 0/1", r_error, byte_count);
        end
`endif
        do_reset();
        start_packet();
        send_byte(8'hC3);
        send_byte(8'hC4);
        n_cmp++;
        if (r_error !== 1'b0 || byte_count !== 7'd2) begin
            n_fail++; $display("FAIL pid_good: r_error=%b count=%0d required 0/2", r_error, byte_count);
        end
        do_reset();
    endtask

    initial begin
        test_reset();
        test_clean_packet();
        test_bad_sync();
        test_early_eop();
        test_simultaneous();
        test_overflow();
        test_reset_mid_packet();
        test_pid();
        repeat (2) @(posedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL wr_missing: %0d expected writes never seen, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/usb_rx_ctrl.md
USB_RX_CTRL -- requirements
Module: usb_rx_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, sole receive-domain clock, rising-edge active.
REQ-002 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port d_edge, input, 1, one-cycle pulse on any D+ transition from the edge detector.
REQ-004 SHALL have port eop, input, 1, SE0 level from the EOP detector.
REQ-005 SHALL have port shift_enable, input, 1, bit-sample strobe from the bit-timer (same strobe the NRZI decoder uses).
REQ-006 SHALL have port byte_received, input, 1, one-cycle pulse when the shift register completes 8 bits.
REQ-007 SHALL have port rcv_data, input, 8, parallel byte from the shift register, LSB first on the wire.
REQ-008 SHALL have port rcving, output, 1, packet reception in progress.
REQ-009 SHALL have port w_enable, output, 1, one-cycle FIFO write strobe for rcv_data.
REQ-010 SHALL have port r_error, output, 1, sticky packet error flag.
REQ-011 SHALL have port packet_done, output, 1, one-cycle pulse on clean packet end.
REQ-012 SHALL have port byte_count, output, 7, bytes stored in the current packet.

Function
REQ-013 SHALL be a registered-state Moore FSM; all outputs except packet_done decode from the current state; latency from input to output is one clk.
REQ-014 SHALL implement states IDLE, SYNC_RX, SYNC_CHK, DATA_RX, STORE, EOP_WAIT, ERR_WAIT, ERR_EOP, ERR_IDLE.
REQ-015 SHALL, in IDLE, move to SYNC_RX on d_edge; this entry also clears r_error and byte_count.
REQ-016 SHALL, in SYNC_RX, move to ERR_EOP on eop&&shift_enable, else to SYNC_CHK on byte_received.
REQ-017 SHALL, in SYNC_CHK, move to DATA_RX if rcv_data==SYNC_BYTE (8'h80), else to ERR_WAIT.
REQ-018 SHALL, in DATA_RX, move to EOP_WAIT on eop&&shift_enable, else to STORE on byte_received; eop wins when both occur in the same cycle, and that byte is not stored.
REQ-019 SHALL, in STORE, assert w_enable for exactly one cycle and increment byte_count; next state DATA_RX, or ERR_WAIT if the increment reaches MAX_BYTES (64).
REQ-020 SHALL, in EOP_WAIT, move to IDLE on d_edge and pulse packet_done in that cycle.
REQ-021 SHALL, in ERR_WAIT, move to ERR_EOP on eop&&shift_enable.
REQ-022 SHALL, in ERR_EOP, move to ERR_IDLE on d_edge.
REQ-023 SHALL, in ERR_IDLE, move to SYNC_RX on d_edge.
REQ-024 SHALL drive rcving=1 in SYNC_RX, SYNC_CHK, DATA_RX, STORE, EOP_WAIT, ERR_WAIT and ERR_EOP, and 0 elsewhere.
REQ-025 SHALL drive r_error=1 in ERR_WAIT, ERR_EOP and ERR_IDLE, and 0 elsewhere.
REQ-026 SHALL ignore byte_received whenever shift_enable has already produced eop in that state, and SHALL hold byte_count unchanged outside STORE; byte_count saturates at MAX_BYTES and never wraps.

Reset
REQ-027 SHALL, while rst=1, force IDLE, rcving=0, w_enable=0, r_error=0, packet_done=0 and byte_count=0, independent of clk.
REQ-028 SHALL, on rst asserted mid-packet, abandon the packet without a w_enable or packet_done pulse, and resume at IDLE on the first clk after rst deasserts.

Configuration
REQ-029 SHALL, when USB_RX_PID_CHECK_EN is defined, check the first stored byte in STORE: if rcv_data[7:4] != ~rcv_data[3:0], w_enable still pulses and the next state is ERR_WAIT.
REQ-030 SHALL, when USB_RX_PID_CHECK_EN is undefined, omit the PID check logic entirely and treat every byte identically.

Structure
REQ-031 SHALL take the state enum, SYNC_BYTE, MAX_BYTES and the byte_count width from shared package usb_rx_pkg.
REQ-032 SHALL contain one sub-module, usb_rx_byte_cnt, a saturating counter with clear and increment inputs; the FSM stays in the top-level module.

Verification
REQ-033 SHALL cover a clean packet: d_edge, sync 8'h80, bytes 8'hC3, 8'hA5, then eop -> two w_enable pulses, byte_count=2, packet_done pulse on the next d_edge, r_error=0.
REQ-034 SHALL cover a bad sync: rcv_data=8'h81 in SYNC_CHK -> r_error=1 until eop then d_edge; the next d_edge returns rcving=1 and r_error=0.
REQ-035 SHALL cover an early EOP: eop&&shift_enable in SYNC_RX -> ERR_EOP, r_error=1, no w_enable.
REQ-036 SHALL cover simultaneous events: eop&&shift_enable with byte_received in DATA_RX -> EOP_WAIT, no w_enable, byte_count unchanged.
REQ-037 SHALL cover overflow: 64 data bytes -> ERR_WAIT after the 64th w_enable, byte_count=64.
REQ-038 SHALL cover reset mid-packet and the PID check: rst during DATA_RX -> all outputs 0 asynchronously; with USB_RX_PID_CHECK_EN defined, PID 8'hC4 -> r_error=1, while 8'hC3 passes.
